// File: rtl/data_ram_ctrl.sv
// data_ram_ctrl: single-port data RAM with byte strobes, valid/ready requests and range checking.
// Define RAM_ZERO_INIT_EN to compile in the post-reset zero-fill sweep.
module data_ram_ctrl #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_wstrb,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_busy
);
  localparam int SW = DATA_W / 8;
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [DATA_W-1:0] mem [DEPTH];
  logic acc, oor;
  logic [IW-1:0] idx;
  assign acc = req_valid & req_ready;
  assign oor = {1'b0, req_addr} >= (ADDR_W+1)'(DEPTH);
  // Only in-range addresses index the array, so dropping the upper bits is safe.
  assign idx = req_addr[IW-1:0];
`ifdef RAM_ZERO_INIT_EN
  typedef enum logic {INIT, RUN} state_t;
  state_t state;
  logic [ADDR_W:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      cnt       <= '0;
      init_busy <= 1'b1;
      req_ready <= 1'b0;
    end else if (state == INIT) begin
      cnt <= cnt + 1'b1;
      if (cnt == (ADDR_W+1)'(DEPTH-1)) begin
        state     <= RUN;
        init_busy <= 1'b0;
        req_ready <= 1'b1;
      end
    end
  end
`else
  assign init_busy = 1'b0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) req_ready <= 1'b0;
    else req_ready <= 1'b1;
  end
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= acc & ~req_we;
      rsp_err   <= acc & oor;
      if (acc && !req_we) rsp_rdata <= oor ? '0 : mem[idx];
    end
  end
  always_ff @(posedge clk) begin
`ifdef RAM_ZERO_INIT_EN
    if (state == INIT) mem[cnt[IW-1:0]] <= '0;
`endif
    if (acc && req_we && !oor)
      for (int i = 0; i < SW; i++)
        if (req_wstrb[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
  end
endmodule

// File: tb/tb_data_ram_ctrl.sv
// tb_data_ram_ctrl: directed and random checks of data_ram_ctrl against a word-array model.
// Works with or without RAM_ZERO_INIT_EN defined.
module tb_data_ram_ctrl;
  localparam int DEPTH = 1000;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0;
  logic [9:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0] req_wstrb = '0;
  logic req_ready, rsp_valid, rsp_err, init_busy;
  logic [31:0] rsp_rdata;
  logic [31:0] model [DEPTH];
  logic [31:0] exp_rdata = '0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  data_ram_ctrl #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .init_busy(init_busy)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset(input string tag);
`ifdef RAM_ZERO_INIT_EN
    chk({tag, "_busy"}, 32'(init_busy), 32'd1);
`else
    chk({tag, "_busy"}, 32'(init_busy), 32'd0);
`endif
    chk({tag, "_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_rdata"}, rsp_rdata, 32'd0);
    exp_rdata = '0;
  endtask
  task automatic wait_ready(input string tag, input int exp_cycles);
    int n = 0;
    while (n < 3 * DEPTH) begin
      @(posedge clk); #1;
      n++;
      if (req_ready === 1'b1) break;
      chk({tag, "_busy_during"}, 32'(init_busy), 32'd1);
    end
    chk({tag, "_cycles"}, 32'(n), 32'(exp_cycles));
    chk({tag, "_busy_after"}, 32'(init_busy), 32'd0);
  endtask
  task automatic do_req(input logic we, input logic [9:0] addr, input logic [31:0] wd, input logic [3:0] ws);
    logic [31:0] m;
    logic oor;
    chk("ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = ws;
    @(posedge clk); #1;
    req_valid = 1'b0;
    oor = int'(addr) >= DEPTH;
    if (!we) exp_rdata = oor ? 32'd0 : model[int'(addr)];
    else if (!oor) begin
      m = {{8{ws[3]}}, {8{ws[2]}}, {8{ws[1]}}, {8{ws[0]}}};
      model[int'(addr)] = (model[int'(addr)] & ~m) | (wd & m);
    end
    chk("rsp_valid", 32'(rsp_valid), 32'(!we));
    chk("rsp_err", 32'(rsp_err), 32'(oor));
    chk("rsp_rdata", rsp_rdata, exp_rdata);
  endtask
  task automatic idle();
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("idle_valid", 32'(rsp_valid), 32'd0);
    chk("idle_err", 32'(rsp_err), 32'd0);
    chk("idle_rdata", rsp_rdata, exp_rdata);
  endtask
  initial begin
    for (int a = 0; a < DEPTH; a++) model[a] = '0;
    #12 chk_reset("reset");
    @(posedge clk); #1 rst_n = 1'b1;
`ifdef RAM_ZERO_INIT_EN
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_reset("midsweep_reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_ready("sweep", DEPTH);
    do_req(1'b0, 10'd5, 32'd0, 4'h0);
    chk("init_zero_5", rsp_rdata, 32'd0);
`else
    @(posedge clk); #1;
    chk("first_edge_ready", 32'(req_ready), 32'd1);
    chk("first_edge_busy", 32'(init_busy), 32'd0);
    rst_n = 1'b0;
    #1 chk_reset("pulse_reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_ready("rerun", 1);
    do_req(1'b1, 10'd0, 32'h600DF00D, 4'hF);
    do_req(1'b0, 10'd0, 32'd0, 4'h0);
    chk("wr_rd_0", rsp_rdata, 32'h600DF00D);
    for (int a = 0; a < DEPTH; a++) do_req(1'b1, 10'(a), $urandom, 4'hF);
`endif
    do_req(1'b1, 10'd3, 32'hDEADBEEF, 4'hF);
    do_req(1'b1, 10'd3, 32'h11223344, 4'b0101);
    do_req(1'b0, 10'd3, 32'd0, 4'h0);
    chk("strobe_merge", rsp_rdata, 32'hDE22BE44);
    idle();
    do_req(1'b1, 10'd7, 32'hA5A5A5A5, 4'hF);
    do_req(1'b0, 10'd7, 32'd0, 4'h0);
    chk("raw_b2b", rsp_rdata, 32'hA5A5A5A5);
    do_req(1'b1, 10'd7, 32'h12345678, 4'h0);
    do_req(1'b0, 10'd7, 32'd0, 4'h0);
    chk("wstrb_zero", rsp_rdata, 32'hA5A5A5A5);
    do_req(1'b0, 10'd1, 32'd0, 4'h0);
    do_req(1'b0, 10'd2, 32'd0, 4'h0);
    do_req(1'b0, 10'd3, 32'd0, 4'h0);
    idle();
    do_req(1'b1, 10'd999, 32'h0BADCAFE, 4'hF);
    do_req(1'b1, 10'd1000, 32'hFFFFFFFF, 4'hF);
    do_req(1'b0, 10'd1023, 32'd0, 4'h0);
    chk("oor_rdata", rsp_rdata, 32'd0);
    do_req(1'b0, 10'd999, 32'd0, 4'h0);
    chk("top_word_kept", rsp_rdata, 32'h0BADCAFE);
    idle();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 7) == 0) idle();
      else do_req(1'($urandom), ($urandom_range(0, 7) == 0) ? 10'($urandom_range(DEPTH, 1023))
                  : 10'($urandom_range(0, DEPTH - 1)), $urandom, 4'($urandom));
    end
    for (int a = 0; a < 20; a++) do_req(1'b0, 10'(a * 50 + 7), 32'd0, 4'h0);
    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
